nios2_debug_vjtag_host: RTL
===========================

Name: nios2_debug_vjtag_host

Overview:
- Host-side initiator for the Nios II debug slave's 2-bit-IR, 38-bit-DR virtual JTAG interface.
- Accepts one {IR, DR} command from system logic and plays it as virtual JTAG scan sequences: UIR, CDR, SDR×DR_WIDTH, UDR.
- Generates tck, drives tdi and the virtual-state strobes, and captures tdo into a 38-bit response.
- Used in bench harnesses and on-chip debug bridges to drive the debug slave without a physical JTAG cable.

Parameters:
- DR_WIDTH, 38: scan-chain length in bits.
- IR_WIDTH, 2: width of ir_in and ir_out.
- TCK_HALF, 2: clk cycles per tck half-period; legal range is 1 to 255.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high reset.
- cmd_valid  in  1: command present.
- cmd_ready  out  1: command accepted when cmd_valid and cmd_ready are both high.
- cmd_ir  in  IR_WIDTH: instruction to load.
- cmd_dr  in  DR_WIDTH: data to shift in, LSB first.
- rsp_valid  out  1: response available.
- rsp_ready  in  1: response consumed.
- rsp_dr  out  DR_WIDTH: captured tdo bits; the first captured bit lands in bit 0.
- rsp_ir_out  out  IR_WIDTH: ir_out sampled during CDR.
- busy  out  1: high whenever state is not IDLE.
- tck  out  1: generated test clock.
- tdi  out  1: serial data to the slave.
- tdo  in  1: serial data from the slave.
- ir_in  out  IR_WIDTH: instruction presented to the slave.
- ir_out  in  IR_WIDTH: status returned by the slave.
- jtag_state_rti  out  1: high in IDLE.
- vs_uir  out  1: virtual state strobe, update-IR.
- vs_cdr  out  1: virtual state strobe, capture-DR.
- vs_sdr  out  1: virtual state strobe, shift-DR.
- vs_udr  out  1: virtual state strobe, update-DR.

Behaviour:
- Clocking and reset
  - Single clock domain (clk). Reset is synchronous and active-high.
  - Reset values: tck=0, tdi=0, ir_in=0, all vs_*=0, jtag_state_rti=1, rsp_valid=0, rsp_dr=0, rsp_ir_out=0, busy=0, half-period counter=0, state=IDLE.
  - Reset asserted mid-scan aborts immediately. No response is produced. The next cycle behaves as after power-up reset.
- tck generation
  - tck free-runs from reset release.
  - A half-period counter counts 0 to TCK_HALF-1. On terminal count, tck toggles and the counter clears.
  - tck_rise strobe: the clk cycle in which tck goes 0→1. tck_fall strobe: the clk cycle in which tck goes 1→0.
- Register timing
  - All outputs except cmd_ready are registered.
  - State, vs_*, ir_in and tdi change only on tck_fall.
  - tdo and ir_out are sampled only on tck_rise.
- cmd_ready = (state==IDLE) && !rsp_valid.
  - On accept: latch cmd_ir into ir_reg and cmd_dr into the shift register shreg.
  - Set pending. busy rises the next clk cycle.
- FSM. Each state except IDLE and RESP lasts whole tck periods, measured fall to fall.
  - IDLE (rti=1): on the first tck_fall with pending set → UIR; load ir_in=ir_reg; clear pending.
  - UIR (vs_uir=1, rti=0): 1 period → CDR.
  - CDR (vs_cdr=1): 1 period; sample ir_out into rsp_ir_out at tck_rise. On exit, tdi=shreg[0] → SDR with bit counter=0.
  - SDR (vs_sdr=1): DR_WIDTH periods.
    - On tck_rise: capture tdo into cap.
    - On tck_fall: shreg <= {cap, shreg[DR_WIDTH-1:1]}; tdi <= new shreg[0]; increment the bit counter.
    - When the counter reaches DR_WIDTH-1 at a fall → UDR.
  - UDR (vs_udr=1): 1 period. At the closing tck_fall: rsp_dr<=shreg, rsp_valid<=1 → RESP.
  - RESP (all vs_*=0, rti=1): stay while rsp_valid=1.
    - On rsp_valid && rsp_ready, clear rsp_valid → IDLE on the same clk edge.
    - A new command can be accepted the following cycle.
- Invariants
  - At most one vs_* strobe is high at any time.
  - ir_in holds its value from UIR entry until the next command's UIR.
  - cmd_valid while busy is ignored, and the command is not consumed.
- Latency from accept to rsp_valid: wait for the next tck_fall (≤ 2·TCK_HALF clk), then (DR_WIDTH+3)·2·TCK_HALF clk. With defaults, 164 clk after the first fall.

Test Plan:
- Reset values: hold reset 5 cycles → tck=0, jtag_state_rti=1, vs_*=0, rsp_valid=0, cmd_ready=1 on the first cycle after release.
- Basic scan (defaults): bench slave model sr preloaded 38'h2A_AAAA_AAAA, tdo=sr[0], shifting on tck posedge; command cmd_ir=2'b01, cmd_dr=38'h15_5555_5555 → rsp_dr=38'h2A_AAAA_AAAA, slave sr=38'h15_5555_5555 at UDR, ir_in=2'b01 from UIR onward, vs_sdr high for exactly 38 tck periods, rsp_valid 164 clk after the first fall.
- Back-pressure: rsp_ready=0 for 50 cycles → rsp_valid and rsp_dr stable, cmd_ready=0; a cmd_valid pulse is not accepted; rsp_ready=1 → cmd_ready=1 the next cycle.
- ir_out capture: slave ir_out=2'b10 → rsp_ir_out=2'b10; a change of ir_out during SDR is not reflected.
- Reset mid-SDR at bit 20 → next cycle all outputs at reset values, no rsp_valid; a following scan completes correctly.
- TCK_HALF=1, DR_WIDTH=8: cmd_dr=8'hC3, slave sr=8'h5A → rsp_dr=8'h5A, slave sr=8'hC3, tck period of 2 clk.

Source files
------------

// File: rtl/nios2_debug_vjtag_host.sv
`default_nettype none
// ============================================================================
// Module   : nios2_debug_vjtag_host
// Purpose  : Host-side initiator for the Nios II debug slave's virtual JTAG
//            port. Takes one {IR, DR} command and plays it out as the
//            virtual-state sequence UIR, CDR, SDR x DR_WIDTH, UDR while
//            generating tck, driving tdi and capturing tdo into a response.
// Ports    : clk/reset           - system clock, synchronous active-high reset
//            cmd_valid/ready/ir/dr - command handshake and payload
//            rsp_valid/ready/dr/ir_out - response handshake and payload
//            busy                - high from command accept until response
//                                  is consumed
//            tck/tdi/tdo         - generated test clock and serial data
//            ir_in/ir_out        - instruction to / status from the slave
//            jtag_state_rti, vs_uir/cdr/sdr/udr - virtual state indications
// Revision : 1.0 - initial release
// ============================================================================
module nios2_debug_vjtag_host #(
  parameter int DR_WIDTH = 38,
  parameter int IR_WIDTH = 2,
  parameter int TCK_HALF = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [IR_WIDTH-1:0] cmd_ir,
  input  logic [DR_WIDTH-1:0] cmd_dr,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DR_WIDTH-1:0] rsp_dr,
  output logic [IR_WIDTH-1:0] rsp_ir_out,
  output logic                busy,
  output logic                tck,
  output logic                tdi,
  input  logic                tdo,
  output logic [IR_WIDTH-1:0] ir_in,
  input  logic [IR_WIDTH-1:0] ir_out,
  output logic                jtag_state_rti,
  output logic                vs_uir,
  output logic                vs_cdr,
  output logic                vs_sdr,
  output logic                vs_udr
);

  localparam int                CNT_W     = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;
  localparam logic [7:0]        HALF_LAST = 8'(TCK_HALF - 1);
  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(DR_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UIR  = 3'd1,
    ST_CDR  = 3'd2,
    ST_SDR  = 3'd3,
    ST_UDR  = 3'd4,
    ST_RESP = 3'd5
  } state_t;

  state_t              state_q;
  logic [7:0]          hcnt_q;
  logic [7:0]          hcnt_d;
  logic                tck_q;
  logic                pending_q;
  logic                busy_q;
  logic [IR_WIDTH-1:0] ir_reg_q;
  logic [IR_WIDTH-1:0] ir_in_q;
  logic [DR_WIDTH-1:0] shreg_q;
  logic                cap_q;
  logic [CNT_W-1:0]    bitcnt_q;
  logic                tdi_q;
  logic                rti_q;
  logic                vs_uir_q;
  logic                vs_cdr_q;
  logic                vs_sdr_q;
  logic                vs_udr_q;
  logic                rsp_valid_q;
  logic [DR_WIDTH-1:0] rsp_dr_q;
  logic [IR_WIDTH-1:0] rsp_ir_out_q;

  logic                w_tick;
  logic                w_tck_rise;
  logic                w_tck_fall;
  logic                w_accept;
  logic [DR_WIDTH-1:0] w_shreg_shift;

  // tck toggles on the half-period terminal count; rise/fall strobes mark
  // the clk cycle whose edge moves tck.
  assign w_tick     = (hcnt_q == HALF_LAST);
  assign w_tck_rise = w_tick & ~tck_q;
  assign w_tck_fall = w_tick &  tck_q;
  assign hcnt_d     = w_tick ? 8'd0 : hcnt_q + 8'd1;

  // A queued-but-not-started command also blocks acceptance so it cannot be
  // overwritten before its UIR begins.
  assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q && !pending_q;
  assign w_accept  = cmd_valid && cmd_ready;

  // Captured bit enters at the MSB so the first captured bit ends up in bit 0.
  assign w_shreg_shift = {cap_q, shreg_q[DR_WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      hcnt_q       <= 8'd0;
      tck_q        <= 1'b0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      ir_reg_q     <= '0;
      ir_in_q      <= '0;
      shreg_q      <= '0;
      cap_q        <= 1'b0;
      bitcnt_q     <= '0;
      tdi_q        <= 1'b0;
      rti_q        <= 1'b1;
      vs_uir_q     <= 1'b0;
      vs_cdr_q     <= 1'b0;
      vs_sdr_q     <= 1'b0;
      vs_udr_q     <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dr_q     <= '0;
      rsp_ir_out_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      if (w_tick) begin
        tck_q <= ~tck_q;
      end

      if (w_accept) begin
        ir_reg_q  <= cmd_ir;
        shreg_q   <= cmd_dr;
        pending_q <= 1'b1;
        busy_q    <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (w_tck_fall && pending_q) begin
            state_q   <= ST_UIR;
            ir_in_q   <= ir_reg_q;
            pending_q <= 1'b0;
            vs_uir_q  <= 1'b1;
            rti_q     <= 1'b0;
          end
        end
        ST_UIR: begin
          if (w_tck_fall) begin
            state_q  <= ST_CDR;
            vs_uir_q <= 1'b0;
            vs_cdr_q <= 1'b1;
          end
        end
        ST_CDR: begin
          if (w_tck_rise) begin
            rsp_ir_out_q <= ir_out;
          end
          if (w_tck_fall) begin
            tdi_q    <= shreg_q[0];
            bitcnt_q <= '0;
            state_q  <= ST_SDR;
            vs_cdr_q <= 1'b0;
            vs_sdr_q <= 1'b1;
          end
        end
        ST_SDR: begin
          if (w_tck_rise) begin
            cap_q <= tdo;
          end
          if (w_tck_fall) begin
            shreg_q  <= w_shreg_shift;
            tdi_q    <= w_shreg_shift[0];
            bitcnt_q <= bitcnt_q + 1'b1;
            if (bitcnt_q == BIT_LAST) begin
              state_q  <= ST_UDR;
              vs_sdr_q <= 1'b0;
              vs_udr_q <= 1'b1;
            end
          end
        end
        ST_UDR: begin
          if (w_tck_fall) begin
            rsp_dr_q    <= shreg_q;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_RESP;
            vs_udr_q    <= 1'b0;
            rti_q       <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid      = rsp_valid_q;
  assign rsp_dr         = rsp_dr_q;
  assign rsp_ir_out     = rsp_ir_out_q;
  assign busy           = busy_q;
  assign tck            = tck_q;
  assign tdi            = tdi_q;
  assign ir_in          = ir_in_q;
  assign jtag_state_rti = rti_q;
  assign vs_uir         = vs_uir_q;
  assign vs_cdr         = vs_cdr_q;
  assign vs_sdr         = vs_sdr_q;
  assign vs_udr         = vs_udr_q;

endmodule
`default_nettype wire
